// File: rtl/arb_pkg.sv
// Shared types and default sizing for the round-robin one-hot arbiter.
package arb_pkg;
  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_e;

  localparam int ARB_NUM_REQ  = 4;
  localparam int ARB_MAX_HOLD = 8;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module rr_pick
  import arb_pkg::*;
#(
  parameter int NUM_REQ = ARB_NUM_REQ,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] pick_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  logic [NUM_REQ-1:0] rot;
  logic [NUM_REQ-1:0] rot_oh;
  int                 sel;

  // Rotate so ptr lands at bit 0, take the lowest set bit, rotate back.
  always_comb begin
    rot    = '0;
    rot_oh = '0;
    pick_o = '0;
    sel    = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rot[i] = req_i[(i + int'(ptr_i)) % NUM_REQ];
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) sel = i;
    end
    if (|rot) rot_oh[sel] = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      pick_o[(i + int'(ptr_i)) % NUM_REQ] = rot_oh[i];
    end
  end

  assign idx_o = IDX_W'((sel + int'(ptr_i)) % NUM_REQ);
  assign any_o = |req_i;

endmodule

// File: rtl/rr_onehot_arb.sv
// Round-robin arbiter with registered one-hot grant, binary index and bounded hold.
module rr_onehot_arb
  import arb_pkg::*;
#(
  parameter int NUM_REQ  = ARB_NUM_REQ,
  parameter int MAX_HOLD = ARB_MAX_HOLD,
  parameter int IDX_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               release_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic               gnt_valid_o,
  output logic [IDX_W-1:0]   gnt_idx_o
);

  localparam int               HOLD_W    = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  arb_state_e          state_q;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [HOLD_W-1:0]   hold_q;
  logic [NUM_REQ-1:0]  gnt_q;
  logic                gnt_valid_q;
  logic [IDX_W-1:0]    gnt_idx_q;

  logic [NUM_REQ-1:0]  pick;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_any;
  logic                exit_busy;

  rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req_i  (req_i),
    .ptr_i  (ptr_q),
    .pick_o (pick),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  assign exit_busy = !req_i[gnt_idx_q] || release_i || (hold_q == HOLD_LAST);
  assign ptr_d     = (int'(gnt_idx_q) == NUM_REQ - 1) ? '0 : gnt_idx_q + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ARB_IDLE;
      ptr_q       <= '0;
      hold_q      <= '0;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      gnt_idx_q   <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (pick_any) begin
            gnt_q       <= pick;
            gnt_idx_q   <= pick_idx;
            gnt_valid_q <= 1'b1;
            hold_q      <= '0;
            state_q     <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          // gnt_idx_q is kept on exit so index consumers see the last owner.
          if (exit_busy) begin
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            ptr_q       <= ptr_d;
            state_q     <= ARB_IDLE;
          end else begin
            hold_q <= hold_q + 1'b1;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign gnt_o       = gnt_q;
  assign gnt_valid_o = gnt_valid_q;
  assign gnt_idx_o   = gnt_idx_q;

endmodule

// File: tb/tb_rr_onehot_arb.sv
// Directed self-checking bench for rr_onehot_arb with NUM_REQ=4, MAX_HOLD=4.
module tb_rr_onehot_arb;

  logic       clk;
  logic       reset_n;
  logic [3:0] req_i;
  logic       release_i;
  logic [3:0] gnt_o;
  logic       gnt_valid_o;
  logic [1:0] gnt_idx_o;

  int total = 0;
  int bad   = 0;

  rr_onehot_arb #(.NUM_REQ(4), .MAX_HOLD(4)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_i       (req_i),
    .release_i   (release_i),
    .gnt_o       (gnt_o),
    .gnt_valid_o (gnt_valid_o),
    .gnt_idx_o   (gnt_idx_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs are driven and outputs sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req_i = 4'b1111; release_i = 1'b0;
    #2;
    for (int k = 0; k < 3; k++) begin
      step();
      total++;
      if (gnt_o !== 4'b0000 || gnt_valid_o !== 1'b0 || gnt_idx_o !== 2'd0) begin
        bad++;
        $display("FAIL reset_hold cyc=%0d got gnt=%b vld=%b idx=%0d exp 0000/0/0", k, gnt_o, gnt_valid_o, gnt_idx_o);
      end
    end
    reset_n = 1'b1;
    step();
    total++;
    if (gnt_o !== 4'b0001 || gnt_valid_o !== 1'b1 || gnt_idx_o !== 2'd0) begin
      bad++;
      $display("FAIL reset_first_gnt got gnt=%b vld=%b idx=%0d exp 0001/1/0", gnt_o, gnt_valid_o, gnt_idx_o);
    end
    req_i = 4'b0000;
    step();  // req dropped -> IDLE, ptr=1
    step();
  endtask

  task automatic test_single();
    release_i = 1'b1;  // no effect in IDLE
    step();
    total++;
    if (gnt_o !== 4'b0000 || gnt_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL idle_release got gnt=%b vld=%b exp 0000/0", gnt_o, gnt_valid_o);
    end
    release_i = 1'b0;
    req_i = 4'b0100;
    step();
    total++;
    if (gnt_o !== 4'b0100 || gnt_valid_o !== 1'b1 || gnt_idx_o !== 2'd2) begin
      bad++;
      $display("FAIL single_gnt got gnt=%b vld=%b idx=%0d exp 0100/1/2", gnt_o, gnt_valid_o, gnt_idx_o);
    end
    req_i = 4'b0000;
    step();
    total++;
    if (gnt_o !== 4'b0000 || gnt_valid_o !== 1'b0 || gnt_idx_o !== 2'd2) begin
      bad++;
      $display("FAIL single_drop got gnt=%b vld=%b idx=%0d exp 0000/0/2", gnt_o, gnt_valid_o, gnt_idx_o);
    end
    req_i = 4'b1111;  // ptr=3 must pick line 3
    step();
    total++;
    if (gnt_o !== 4'b1000 || gnt_idx_o !== 2'd3) begin
      bad++;
      $display("FAIL single_ptr got gnt=%b idx=%0d exp 1000/3", gnt_o, gnt_idx_o);
    end
    req_i = 4'b0000;
    step();  // ptr wraps to 0
    step();
  endtask

  task automatic test_rotation();
    logic [3:0] exp_seq [9];
    exp_seq = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
    req_i = 4'b1111;
    for (int k = 0; k < 9; k++) begin
      step();
      total++;
      if (gnt_o !== exp_seq[k] || gnt_valid_o !== (exp_seq[k] != 4'b0000)) begin
        bad++;
        $display("FAIL rotation cyc=%0d got gnt=%b vld=%b exp %b", k, gnt_o, gnt_valid_o, exp_seq[k]);
      end
      release_i = (exp_seq[k] != 4'b0000);
    end
    step();
    release_i = 1'b0;
    req_i = 4'b0000;
    step();
  endtask

  task automatic test_timeout();
    logic [3:0] exp_seq [11];
    exp_seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000,
                4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0001};
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    req_i = 4'b0011;
    for (int k = 0; k < 11; k++) begin
      step();
      total++;
      if (gnt_o !== exp_seq[k] || gnt_valid_o !== (exp_seq[k] != 4'b0000)) begin
        bad++;
        $display("FAIL timeout cyc=%0d got gnt=%b vld=%b exp %b", k, gnt_o, gnt_valid_o, exp_seq[k]);
      end
    end
    req_i = 4'b0000;
    step();  // ptr=1
    step();
  endtask

  task automatic test_interference();
    req_i = 4'b0010;
    step();
    total++;
    if (gnt_o !== 4'b0010 || gnt_idx_o !== 2'd1) begin
      bad++;
      $display("FAIL intf_gnt got gnt=%b idx=%0d exp 0010/1", gnt_o, gnt_idx_o);
    end
    req_i = 4'b1011;
    for (int k = 0; k < 2; k++) begin
      step();
      total++;
      if (gnt_o !== 4'b0010 || gnt_valid_o !== 1'b1) begin
        bad++;
        $display("FAIL intf_hold cyc=%0d got gnt=%b vld=%b exp 0010/1", k, gnt_o, gnt_valid_o);
      end
    end
    release_i = 1'b1;
    req_i = 4'b1001;
    step();
    total++;
    if (gnt_o !== 4'b0000 || gnt_valid_o !== 1'b0 || gnt_idx_o !== 2'd1) begin
      bad++;
      $display("FAIL intf_drop got gnt=%b vld=%b idx=%0d exp 0000/0/1", gnt_o, gnt_valid_o, gnt_idx_o);
    end
    release_i = 1'b0;
    step();  // ptr=2, req 1001 -> line 3
    total++;
    if (gnt_o !== 4'b1000 || gnt_idx_o !== 2'd3) begin
      bad++;
      $display("FAIL intf_next got gnt=%b idx=%0d exp 1000/3", gnt_o, gnt_idx_o);
    end
  endtask

  task automatic test_reset_mid_busy();
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if (gnt_o !== 4'b0000 || gnt_valid_o !== 1'b0 || gnt_idx_o !== 2'd0) begin
      bad++;
      $display("FAIL async_clear got gnt=%b vld=%b idx=%0d exp 0000/0/0", gnt_o, gnt_valid_o, gnt_idx_o);
    end
    req_i = 4'b1010;
    #2;
    reset_n = 1'b1;
    step();
    total++;
    if (gnt_o !== 4'b0010 || gnt_idx_o !== 2'd1 || gnt_valid_o !== 1'b1) begin
      bad++;
      $display("FAIL reset_ptr got gnt=%b vld=%b idx=%0d exp 0010/1/1", gnt_o, gnt_valid_o, gnt_idx_o);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && !$onehot0(gnt_o)) begin
      total++;
      bad++;
      $display("FAIL onehot got gnt=%b exp zero or one-hot", gnt_o);
    end
  end

  initial begin
    reset_n = 1'b0; req_i = '0; release_i = 1'b0;
    test_reset();
    test_single();
    test_rotation();
    test_timeout();
    test_interference();
    test_reset_mid_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
